// File: rtl/coax_control_pkg.sv
// Shared constants, state encoding and helpers for the coax SPI command controller.
package coax_control_pkg;

  localparam int unsigned WORD_WIDTH   = 10;
  localparam int unsigned MAX_CHANNELS = 4;

  // Opcodes carried in command byte bits [3:0]
  localparam logic [3:0] OP_READ_REG  = 4'h2;
  localparam logic [3:0] OP_WRITE_REG = 4'h3;
  localparam logic [3:0] OP_TX        = 4'h4;
  localparam logic [3:0] OP_RX        = 4'h5;
  localparam logic [3:0] OP_START     = 4'h6;
  localparam logic [3:0] OP_RESET     = 4'hF;

  // Register addresses
  localparam logic [3:0] REG_STATUS_LAST = 4'h3;
  localparam logic [3:0] REG_CONTROL     = 4'h8;
  localparam logic [3:0] REG_CHANNELS    = 4'h9;
  localparam logic [3:0] REG_MAGIC       = 4'hF;
  localparam logic [7:0] MAGIC_VALUE     = 8'hA5;

  // Bit positions in a channel status byte
  localparam int unsigned STAT_TX_EMPTY  = 1;
  localparam int unsigned STAT_TX_ACTIVE = 2;
  localparam int unsigned STAT_TX_FULL   = 3;
  localparam int unsigned STAT_RX_EMPTY  = 4;
  localparam int unsigned STAT_RX_ACTIVE = 5;
  localparam int unsigned STAT_RX_ERROR  = 6;

  // Response codes
  localparam logic [7:0] RESP_OK           = 8'h00;
  localparam logic [7:0] RESP_TX_FULL      = 8'h81;
  localparam logic [7:0] RESP_TX_NOT_READY = 8'h82;
  localparam logic [7:0] RESP_BAD_CHANNEL  = 8'hFF;

  typedef enum logic [3:0] {
    StIdle,
    StRd1,
    StRd2,
    StWr,
    StTx1,
    StTx2,
    StRx1,
    StRx2,
    StRx3,
    StRx4,
    StStart,
    StReset,
    StBad
  } state_t;

  // Select channel ch's word from the packed rx_data bus (zero-extended to MAX_CHANNELS)
  function automatic logic [WORD_WIDTH-1:0] rx_word_sel(
    input logic [MAX_CHANNELS*WORD_WIDTH-1:0] words,
    input logic [1:0]                         ch
  );
    return words[32'(ch)*WORD_WIDTH +: WORD_WIDTH];
  endfunction

  // Assemble a channel status byte
  function automatic logic [7:0] status_byte(
    input logic rx_err,
    input logic rx_act,
    input logic rx_emp,
    input logic tx_ful,
    input logic tx_act,
    input logic tx_emp
  );
    logic [7:0] s;
    s                 = 8'h00;
    s[STAT_RX_ERROR]  = rx_err;
    s[STAT_RX_ACTIVE] = rx_act;
    s[STAT_RX_EMPTY]  = rx_emp;
    s[STAT_TX_FULL]   = tx_ful;
    s[STAT_TX_ACTIVE] = tx_act;
    s[STAT_TX_EMPTY]  = tx_emp;
    return s;
  endfunction

endpackage

// File: rtl/control_multi.sv
// SPI command controller for CHANNELS coax TX/RX pairs: register access, TX FIFO loading,
// RX streaming, TX start and masked channel reset. All outputs are registered.
module control_multi
  import coax_control_pkg::*;
#(
  parameter int unsigned CHANNELS      = 2,
  parameter logic [7:0]  CONTROL_RESET = 8'h80
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           spi_cs,
  input  logic [7:0]                     spi_rx_data,
  input  logic                           spi_rx_strobe,
  output logic [7:0]                     spi_tx_data,
  output logic                           spi_tx_strobe,
  output logic [CHANNELS-1:0]            loopback,
  output logic [CHANNELS-1:0]            tx_reset,
  input  logic [CHANNELS-1:0]            tx_active,
  output logic [WORD_WIDTH-1:0]          tx_data,
  output logic [CHANNELS-1:0]            tx_load_strobe,
  output logic [CHANNELS-1:0]            tx_start_strobe,
  input  logic [CHANNELS-1:0]            tx_empty,
  input  logic [CHANNELS-1:0]            tx_full,
  input  logic [CHANNELS-1:0]            tx_ready,
  output logic [CHANNELS-1:0]            rx_reset,
  input  logic [CHANNELS-1:0]            rx_active,
  input  logic [CHANNELS-1:0]            rx_error,
  input  logic [CHANNELS-1:0]            rx_empty,
  input  logic [WORD_WIDTH*CHANNELS-1:0] rx_data,
  output logic [CHANNELS-1:0]            rx_read_strobe
);

  localparam logic [3:0] CHAN_COUNT = 4'(CHANNELS);

  state_t                state_q;
  logic [3:0]            arg_q;
  logic [1:0]            ch_q;
  logic [7:0]            ctrl_q;
  logic [15:0]           rx_buf_q;
  logic                  tx_data_valid_q;
  logic [7:0]            spi_tx_data_q;
  logic                  spi_tx_strobe_q;
  logic [WORD_WIDTH-1:0] tx_data_q;
  logic [CHANNELS-1:0]   load_q;
  logic [CHANNELS-1:0]   start_q;
  logic [CHANNELS-1:0]   tx_reset_q;
  logic [CHANNELS-1:0]   rx_reset_q;
  logic [CHANNELS-1:0]   rd_q;

  // Channel status widened to four lanes so a 2-bit channel index always fits
  logic [3:0] tx_active_x, tx_empty_x, tx_full_x, tx_ready_x;
  logic [3:0] rx_active_x, rx_error_x, rx_empty_x;
  logic [MAX_CHANNELS*WORD_WIDTH-1:0] rx_data_x;

  logic [CHANNELS-1:0] start_ok;
  logic [CHANNELS-1:0] reset_mask;
  logic [CHANNELS-1:0] ch_onehot;
  logic [7:0]          reg_value;
  logic                arg_bad_channel;

  // Widen inputs and derive masks shared by several states
  always_comb begin
    tx_active_x     = 4'(tx_active);
    tx_empty_x      = 4'(tx_empty);
    tx_full_x       = 4'(tx_full);
    tx_ready_x      = 4'(tx_ready);
    rx_active_x     = 4'(rx_active);
    rx_error_x      = 4'(rx_error);
    rx_empty_x      = 4'(rx_empty);
    rx_data_x       = (MAX_CHANNELS*WORD_WIDTH)'(rx_data);
    start_ok        = ~tx_empty & ~tx_active;
    reset_mask      = CHANNELS'((arg_q == 4'h0) ? 4'hF : arg_q);
    ch_onehot       = CHANNELS'(1'b1) << ch_q;
    arg_bad_channel = (spi_rx_data[7:4] >= CHAN_COUNT);
  end

  // Register read multiplexer, addressed by the latched command argument
  always_comb begin
    reg_value = 8'h00;
    if (arg_q <= REG_STATUS_LAST) begin
      if (arg_q < CHAN_COUNT) begin
        reg_value = status_byte(rx_error_x[arg_q[1:0]], rx_active_x[arg_q[1:0]],
                                rx_empty_x[arg_q[1:0]], tx_full_x[arg_q[1:0]],
                                tx_active_x[arg_q[1:0]], tx_empty_x[arg_q[1:0]]);
      end
    end else begin
      case (arg_q)
        REG_CONTROL:  reg_value = ctrl_q;
        REG_CHANNELS: reg_value = 8'(CHANNELS);
        REG_MAGIC:    reg_value = MAGIC_VALUE;
        default:      reg_value = 8'h00;
      endcase
    end
  end

  // Command FSM with registered strobes; CS deselect overrides at the end of the block
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= StIdle;
      arg_q           <= 4'h0;
      ch_q            <= 2'd0;
      ctrl_q          <= CONTROL_RESET;
      rx_buf_q        <= 16'h0000;
      tx_data_valid_q <= 1'b0;
      spi_tx_data_q   <= 8'h00;
      spi_tx_strobe_q <= 1'b0;
      tx_data_q       <= '0;
      load_q          <= '0;
      start_q         <= '0;
      tx_reset_q      <= '0;
      rx_reset_q      <= '0;
      rd_q            <= '0;
    end else begin
      spi_tx_strobe_q <= 1'b0;
      load_q          <= '0;
      start_q         <= '0;
      tx_reset_q      <= '0;
      rx_reset_q      <= '0;
      rd_q            <= '0;

      case (state_q)
        StIdle: begin
          if (spi_rx_strobe) begin
            arg_q <= spi_rx_data[7:4];
            ch_q  <= spi_rx_data[5:4];
            case (spi_rx_data[3:0])
              OP_READ_REG:  state_q <= StRd1;
              OP_WRITE_REG: state_q <= StWr;
              OP_TX:        state_q <= arg_bad_channel ? StBad : StTx1;
              OP_RX:        state_q <= arg_bad_channel ? StBad : StRx1;
              OP_START:     state_q <= StStart;
              OP_RESET:     state_q <= StReset;
              default:      state_q <= StIdle;
            endcase
          end
        end
        StRd1: begin
          spi_tx_strobe_q <= 1'b1;
          spi_tx_data_q   <= reg_value;
          state_q         <= StRd2;
        end
        StRd2: begin
          if (spi_rx_strobe) state_q <= StRd1;
        end
        StWr: begin
          if (spi_rx_strobe) begin
            if (arg_q == REG_CONTROL) ctrl_q <= spi_rx_data;
            spi_tx_strobe_q <= 1'b1;
            spi_tx_data_q   <= RESP_OK;
          end
        end
        StTx1: begin
          // A rejected high byte still consumes its pair; valid stays low so TX2 loads nothing
          if (spi_rx_strobe) begin
            spi_tx_strobe_q <= 1'b1;
            state_q         <= StTx2;
            if (tx_full_x[ch_q]) begin
              spi_tx_data_q   <= RESP_TX_FULL;
              tx_data_valid_q <= 1'b0;
            end else if (!tx_ready_x[ch_q]) begin
              spi_tx_data_q   <= RESP_TX_NOT_READY;
              tx_data_valid_q <= 1'b0;
            end else begin
              spi_tx_data_q   <= RESP_OK;
              tx_data_q[9:8]  <= spi_rx_data[1:0];
              tx_data_valid_q <= 1'b1;
            end
          end
        end
        StTx2: begin
          if (spi_rx_strobe) begin
            tx_data_q[7:0]  <= spi_rx_data;
            load_q          <= tx_data_valid_q ? ch_onehot : '0;
            tx_data_valid_q <= 1'b0;
            spi_tx_strobe_q <= 1'b1;
            spi_tx_data_q   <= RESP_OK;
            state_q         <= StTx1;
          end
        end
        StRx1: begin
          rx_buf_q <= {rx_error_x[ch_q], rx_empty_x[ch_q], 4'b0000, rx_word_sel(rx_data_x, ch_q)};
          state_q  <= StRx2;
        end
        StRx2: begin
          spi_tx_strobe_q <= 1'b1;
          spi_tx_data_q   <= rx_buf_q[15:8];
          state_q         <= StRx3;
        end
        StRx3: begin
          if (spi_rx_strobe) begin
            spi_tx_strobe_q <= 1'b1;
            spi_tx_data_q   <= rx_buf_q[7:0];
            // An errored word flushes the receiver instead of dequeuing
            if (rx_buf_q[15])      rx_reset_q <= ch_onehot;
            else if (!rx_buf_q[14]) rd_q      <= ch_onehot;
            state_q <= StRx4;
          end
        end
        StRx4: begin
          if (spi_rx_strobe) state_q <= StRx1;
        end
        StStart: begin
          start_q <= start_ok & CHANNELS'(arg_q);
          state_q <= StIdle;
        end
        StReset: begin
          tx_reset_q <= reset_mask;
          rx_reset_q <= reset_mask;
          state_q    <= StIdle;
        end
        StBad: begin
          if (spi_rx_strobe) begin
            spi_tx_strobe_q <= 1'b1;
            spi_tx_data_q   <= RESP_BAD_CHANNEL;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Deselect aborts everything except a TX2 load already in flight
      if (spi_cs) begin
        state_q         <= StIdle;
        tx_data_valid_q <= 1'b0;
        spi_tx_strobe_q <= 1'b0;
        tx_reset_q      <= '0;
        rx_reset_q      <= '0;
        rd_q            <= '0;
        start_q         <= ctrl_q[7] ? start_ok : '0;
      end
    end
  end

  assign spi_tx_data     = spi_tx_data_q;
  assign spi_tx_strobe   = spi_tx_strobe_q;
  assign loopback        = ctrl_q[CHANNELS-1:0];
  assign tx_reset        = tx_reset_q;
  assign rx_reset        = rx_reset_q;
  assign tx_data         = tx_data_q;
  assign tx_load_strobe  = load_q;
  assign tx_start_strobe = start_q;
  assign rx_read_strobe  = rd_q;

endmodule

// File: tb/tb_control_multi.sv
// Directed self-checking bench for control_multi with CHANNELS = 2.
module tb_control_multi;

  logic        clk;
  logic        reset;
  logic        spi_cs;
  logic [7:0]  spi_rx_data;
  logic        spi_rx_strobe;
  logic [7:0]  spi_tx_data;
  logic        spi_tx_strobe;
  logic [1:0]  loopback;
  logic [1:0]  tx_reset;
  logic [1:0]  tx_active;
  logic [9:0]  tx_data;
  logic [1:0]  tx_load_strobe;
  logic [1:0]  tx_start_strobe;
  logic [1:0]  tx_empty;
  logic [1:0]  tx_full;
  logic [1:0]  tx_ready;
  logic [1:0]  rx_reset;
  logic [1:0]  rx_active;
  logic [1:0]  rx_error;
  logic [1:0]  rx_empty;
  logic [19:0] rx_data;
  logic [1:0]  rx_read_strobe;

  int n_checks = 0;
  int n_pass   = 0;

  control_multi #(
    .CHANNELS      (2),
    .CONTROL_RESET (8'h80)
  ) u_dut (
    .clk             (clk),
    .reset           (reset),
    .spi_cs          (spi_cs),
    .spi_rx_data     (spi_rx_data),
    .spi_rx_strobe   (spi_rx_strobe),
    .spi_tx_data     (spi_tx_data),
    .spi_tx_strobe   (spi_tx_strobe),
    .loopback        (loopback),
    .tx_reset        (tx_reset),
    .tx_active       (tx_active),
    .tx_data         (tx_data),
    .tx_load_strobe  (tx_load_strobe),
    .tx_start_strobe (tx_start_strobe),
    .tx_empty        (tx_empty),
    .tx_full         (tx_full),
    .tx_ready        (tx_ready),
    .rx_reset        (rx_reset),
    .rx_active       (rx_active),
    .rx_error        (rx_error),
    .rx_empty        (rx_empty),
    .rx_data         (rx_data),
    .rx_read_strobe  (rx_read_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Advance one clock; sample point is 1ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one SPI byte for exactly one clock
  task automatic send(input logic [7:0] b);
    spi_rx_data   = b;
    spi_rx_strobe = 1'b1;
    tick();
    spi_rx_strobe = 1'b0;
  endtask

  task automatic deselect();
    spi_cs = 1'b1;
    tick();
    tick();
  endtask

  // Reg-read vectors: {command, expected byte}
  logic [7:0] rd_vec [4][2];

  initial begin
    reset         = 1'b0;
    spi_cs        = 1'b1;
    spi_rx_data   = 8'h00;
    spi_rx_strobe = 1'b0;
    tx_active     = 2'b00;
    tx_empty      = 2'b11;
    tx_full       = 2'b00;
    tx_ready      = 2'b11;
    rx_active     = 2'b00;
    rx_error      = 2'b00;
    rx_empty      = 2'b00;
    rx_data       = 20'h0;
    tick();
    tick();
    check_eq("rst_tx_strobe", 32'(spi_tx_strobe), 32'h0);
    check_eq("rst_loopback", 32'(loopback), 32'h0);
    check_eq("rst_tx_data", 32'(tx_data), 32'h0);
    check_eq("rst_resets", 32'({tx_reset, rx_reset}), 32'h0);
    reset = 1'b1;
    tick();

    // Magic register, re-sampled on each dummy byte
    spi_cs = 1'b0;
    send(8'hF2);
    tick();
    check_eq("rd_magic_first", 32'({spi_tx_strobe, spi_tx_data}), 32'h1A5);
    for (int i = 0; i < 3; i++) begin
      send(8'h00);
      check_eq("rd_magic_gap", 32'(spi_tx_strobe), 32'h0);
      tick();
      check_eq("rd_magic_byte", 32'({spi_tx_strobe, spi_tx_data}), 32'h1A5);
    end
    deselect();

    // Control register write then read back
    spi_cs = 1'b0;
    send(8'h83);
    send(8'h05);
    check_eq("wr_echo", 32'({spi_tx_strobe, spi_tx_data}), 32'h100);
    check_eq("wr_loopback", 32'(loopback), 32'h1);
    deselect();
    spi_cs = 1'b0;
    send(8'h82);
    tick();
    check_eq("rd_control", 32'({spi_tx_strobe, spi_tx_data}), 32'h105);
    deselect();

    // Other registers: CHANNELS, status ch1, status ch2 (absent), unmapped address
    tx_full   = 2'b10;
    rx_active = 2'b10;
    rd_vec[0] = '{8'h92, 8'h02};
    rd_vec[1] = '{8'h12, 8'h2A};
    rd_vec[2] = '{8'h22, 8'h00};
    rd_vec[3] = '{8'h72, 8'h00};
    for (int i = 0; i < 4; i++) begin
      spi_cs = 1'b0;
      send(rd_vec[i][0]);
      tick();
      check_eq("rd_reg_vec", 32'({spi_tx_strobe, spi_tx_data}), 32'({1'b1, rd_vec[i][1]}));
      deselect();
    end
    tx_full   = 2'b00;
    rx_active = 2'b00;

    // TX word on channel 1
    spi_cs = 1'b0;
    send(8'h14);
    send(8'h02);
    check_eq("tx1_resp", 32'({spi_tx_strobe, spi_tx_data}), 32'h100);
    send(8'h5A);
    check_eq("tx_load", 32'(tx_load_strobe), 32'h2);
    check_eq("tx_word", 32'(tx_data), 32'h25A);
    tick();
    check_eq("tx_load_1cyc", 32'(tx_load_strobe), 32'h0);
    deselect();

    // TX full and not-ready rejections on channel 0
    tx_full = 2'b01;
    spi_cs  = 1'b0;
    send(8'h04);
    send(8'h00);
    check_eq("tx_full_resp", 32'({spi_tx_strobe, spi_tx_data}), 32'h181);
    send(8'h11);
    check_eq("tx_full_noload", 32'(tx_load_strobe), 32'h0);
    tx_full  = 2'b00;
    tx_ready = 2'b10;
    send(8'h00);
    check_eq("tx_notready_resp", 32'({spi_tx_strobe, spi_tx_data}), 32'h182);
    send(8'h11);
    check_eq("tx_notready_noload", 32'(tx_load_strobe), 32'h0);
    tx_ready = 2'b11;
    deselect();

    // Bad channel
    spi_cs = 1'b0;
    send(8'h34);
    for (int i = 0; i < 2; i++) begin
      send(8'h12);
      check_eq("bad_resp", 32'({spi_tx_strobe, spi_tx_data}), 32'h1FF);
      check_eq("bad_nostrobe", 32'({tx_load_strobe, rx_read_strobe}), 32'h0);
    end
    deselect();

    // RX stream from channel 1, clean word
    rx_data = {10'h3C1, 10'h000};
    spi_cs  = 1'b0;
    send(8'h15);
    tick();
    tick();
    check_eq("rx_high", 32'({spi_tx_strobe, spi_tx_data}), 32'h103);
    send(8'h00);
    check_eq("rx_low", 32'({spi_tx_strobe, spi_tx_data}), 32'h1C1);
    check_eq("rx_read", 32'({rx_read_strobe, rx_reset}), 32'h8);
    send(8'h00);
    check_eq("rx_read_1cyc", 32'(rx_read_strobe), 32'h0);
    tick();
    tick();
    check_eq("rx_stream_high", 32'({spi_tx_strobe, spi_tx_data}), 32'h103);
    deselect();

    // RX with error flag
    rx_error = 2'b10;
    spi_cs   = 1'b0;
    send(8'h15);
    tick();
    tick();
    check_eq("rx_err_high", 32'({spi_tx_strobe, spi_tx_data}), 32'h183);
    send(8'h00);
    check_eq("rx_err_low", 32'({spi_tx_strobe, spi_tx_data}), 32'h1C1);
    check_eq("rx_err_reset", 32'({rx_read_strobe, rx_reset}), 32'h2);
    rx_error = 2'b00;
    deselect();

    // Reset all channels (mask 0)
    spi_cs = 1'b0;
    send(8'h0F);
    tick();
    check_eq("reset_all", 32'({tx_reset, rx_reset}), 32'hF);
    tick();
    check_eq("reset_1cyc", 32'({tx_reset, rx_reset}), 32'h0);
    deselect();

    // Explicit start: only channel 1 is non-empty and idle
    tx_empty  = 2'b00;
    tx_active = 2'b01;
    spi_cs    = 1'b0;
    send(8'h36);
    tick();
    check_eq("start_masked", 32'(tx_start_strobe), 32'h2);
    tick();
    check_eq("start_1cyc", 32'(tx_start_strobe), 32'h0);
    tx_empty  = 2'b11;
    tx_active = 2'b00;
    deselect();

    // Auto start on deselect with control bit 7 set
    spi_cs = 1'b0;
    send(8'h83);
    send(8'h80);
    tx_empty = 2'b10;
    spi_cs   = 1'b1;
    tick();
    check_eq("auto_start", 32'(tx_start_strobe), 32'h1);
    tick();
    check_eq("auto_start_repeat", 32'(tx_start_strobe), 32'h1);
    tx_empty = 2'b11;
    tick();
    check_eq("auto_start_off", 32'(tx_start_strobe), 32'h0);

    // Reset asserted while TX2 byte is presented
    spi_cs = 1'b0;
    send(8'h83);
    send(8'h03);
    deselect();
    spi_cs = 1'b0;
    send(8'h04);
    send(8'h01);
    spi_rx_data   = 8'h33;
    spi_rx_strobe = 1'b1;
    reset         = 1'b0;
    tick();
    spi_rx_strobe = 1'b0;
    check_eq("midrst_noload", 32'(tx_load_strobe), 32'h0);
    check_eq("midrst_tx_data", 32'(tx_data), 32'h0);
    check_eq("midrst_loopback", 32'(loopback), 32'h0);
    check_eq("midrst_tx_strobe", 32'(spi_tx_strobe), 32'h0);
    reset  = 1'b1;
    spi_cs = 1'b1;
    tick();
    check_eq("postrst_noload", 32'(tx_load_strobe), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
